// File: rtl/puf_race_sequencer.sv
// puf_race_sequencer
// Runs one host request through the PUF datapath. It latches the challenge, then for
// each response byte it pulses the smart buffer's ack/reset, lets the race run until
// 8 bits are captured, and hands the byte to the UART transmitter. The challenge is
// bumped between bytes.
// Optional feature: define PUF_RACE_TIMEOUT_EN to bound the RACE state. On expiry the
// sequencer sends 8'hEE, raises timeout_err and drops the rest of the request.
module puf_race_sequencer #(
   parameter int CHAL_W         = 16,
   parameter int NUM_BYTES      = 4,
   parameter int ACK_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              chal_valid,
   input  logic [CHAL_W-1:0] chal_data,
   output logic              chal_ready,
   input  logic              buf_ready,
   input  logic [7:0]        buf_data,
   output logic              buf_ack_reset,
   output logic              race_en,
   output logic [CHAL_W-1:0] challenge,
   output logic              tx_valid,
   output logic [7:0]        tx_data,
   input  logic              tx_ready,
   output logic              busy,
   output logic [7:0]        byte_idx,
   output logic              timeout_err
);

   localparam int              ACK_W    = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
   localparam logic [ACK_W-1:0] ACK_LOAD = ACK_W'(ACK_CYCLES - 1);
   localparam logic [7:0]       LAST_IDX = 8'(NUM_BYTES - 1);

   if ((NUM_BYTES < 1) || (NUM_BYTES > 255)) begin : g_bad_num_bytes
      $error("NUM_BYTES must be in 1..255");
   end
   if (ACK_CYCLES < 1) begin : g_bad_ack_cycles
      $error("ACK_CYCLES must be at least 1");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RACE  = 2'd2,
      SEND  = 2'd3
   } state_t;

   state_t              state_q;
   state_t              state_nxt;
   logic [ACK_W-1:0]    ack_cnt_q;
   logic [ACK_W-1:0]    ack_cnt_nxt;
   logic                buf_ack_reset_nxt;
   logic                race_en_nxt;
   logic [CHAL_W-1:0]   challenge_nxt;
   logic                tx_valid_nxt;
   logic [7:0]          tx_data_nxt;
   logic [7:0]          byte_idx_nxt;
   logic                accept;
   logic                timed_out;
   logic                abort;

   assign accept = (state_q == IDLE) && chal_valid && chal_ready;

`ifdef PUF_RACE_TIMEOUT_EN
   localparam int             TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] to_cnt_q;
   logic [TO_W-1:0] to_cnt_nxt;
   logic            timeout_err_q;
   logic            timeout_err_nxt;

   // A captured byte on the final allowed cycle takes priority over the timeout.
   assign timed_out   = (state_q == RACE) && !buf_ready && (to_cnt_q == TO_LAST);
   assign abort       = timeout_err_q;
   assign timeout_err = timeout_err_q;

   // Race cycle counter restarts from zero every time RACE is entered; sticky error is
   // cleared only when a new challenge is accepted.
   always_comb begin
      to_cnt_nxt      = '0;
      timeout_err_nxt = timeout_err_q;
      if (state_q == RACE) begin
         to_cnt_nxt = to_cnt_q + TO_W'(1);
      end
      if (accept) begin
         timeout_err_nxt = 1'b0;
      end else if (timed_out) begin
         timeout_err_nxt = 1'b1;
      end
   end

   // Timeout counter and sticky flag registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         to_cnt_q      <= to_cnt_nxt;
         timeout_err_q <= timeout_err_nxt;
      end
   end
`else
   assign timed_out   = 1'b0;
   assign abort       = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // Next-state and next-output logic; every output is registered from these values.
   always_comb begin
      state_nxt         = state_q;
      ack_cnt_nxt       = ack_cnt_q;
      buf_ack_reset_nxt = buf_ack_reset;
      race_en_nxt       = race_en;
      challenge_nxt     = challenge;
      tx_valid_nxt      = tx_valid;
      tx_data_nxt       = tx_data;
      byte_idx_nxt      = byte_idx;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               challenge_nxt     = chal_data;
               byte_idx_nxt      = 8'd0;
               ack_cnt_nxt       = ACK_LOAD;
               buf_ack_reset_nxt = 1'b1;
               state_nxt         = CLEAR;
            end
         end
         CLEAR: begin
            if (ack_cnt_q == '0) begin
               buf_ack_reset_nxt = 1'b0;
               race_en_nxt       = 1'b1;
               state_nxt         = RACE;
            end else begin
               ack_cnt_nxt = ack_cnt_q - ACK_W'(1);
            end
         end
         RACE: begin
            if (buf_ready) begin
               tx_data_nxt  = buf_data;
               race_en_nxt  = 1'b0;
               tx_valid_nxt = 1'b1;
               state_nxt    = SEND;
            end else if (timed_out) begin
               tx_data_nxt  = 8'hEE;
               race_en_nxt  = 1'b0;
               tx_valid_nxt = 1'b1;
               state_nxt    = SEND;
            end
         end
         SEND: begin
            // tx_valid is always high here, so tx_ready alone completes the handshake.
            if (tx_ready) begin
               tx_valid_nxt = 1'b0;
               if ((byte_idx == LAST_IDX) || abort) begin
                  state_nxt = IDLE;
               end else begin
                  byte_idx_nxt      = byte_idx + 8'd1;
                  challenge_nxt     = challenge + CHAL_W'(1);
                  ack_cnt_nxt       = ACK_LOAD;
                  buf_ack_reset_nxt = 1'b1;
                  state_nxt         = CLEAR;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and output registers; chal_ready/busy follow the state being entered.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         ack_cnt_q     <= '0;
         chal_ready    <= 1'b1;
         buf_ack_reset <= 1'b0;
         race_en       <= 1'b0;
         challenge     <= '0;
         tx_valid      <= 1'b0;
         tx_data       <= 8'd0;
         busy          <= 1'b0;
         byte_idx      <= 8'd0;
      end else begin
         state_q       <= state_nxt;
         ack_cnt_q     <= ack_cnt_nxt;
         chal_ready    <= (state_nxt == IDLE);
         buf_ack_reset <= buf_ack_reset_nxt;
         race_en       <= race_en_nxt;
         challenge     <= challenge_nxt;
         tx_valid      <= tx_valid_nxt;
         tx_data       <= tx_data_nxt;
         busy          <= (state_nxt != IDLE);
         byte_idx      <= byte_idx_nxt;
      end
   end

endmodule

// File: tb/tb_puf_race_sequencer.sv
// tb_puf_race_sequencer
// Randomized bench for puf_race_sequencer with a queue-based scoreboard. The request
// driver derives each expected response byte (data, challenge, index) from the
// request-level rules and pushes it; an independent monitor pops on every tx handshake.
// Build with PUF_RACE_TIMEOUT_EN defined to also cover the race timeout.
module tb_puf_race_sequencer;

   localparam int CHAL_W         = 16;
   localparam int NUM_BYTES      = 4;
   localparam int ACK_CYCLES     = 4;
   localparam int TIMEOUT_CYCLES = 16;
`ifdef PUF_RACE_TIMEOUT_EN
   localparam bit TIMEOUT_ON = 1'b1;
`else
   localparam bit TIMEOUT_ON = 1'b0;
`endif

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              chal_valid = 1'b0;
   logic [CHAL_W-1:0] chal_data = '0;
   logic              chal_ready;
   logic              buf_ready = 1'b0;
   logic [7:0]        buf_data = 8'd0;
   logic              buf_ack_reset;
   logic              race_en;
   logic [CHAL_W-1:0] challenge;
   logic              tx_valid;
   logic [7:0]        tx_data;
   logic              tx_ready = 1'b0;
   logic              busy;
   logic [7:0]        byte_idx;
   logic              timeout_err;

   puf_race_sequencer #(
      .CHAL_W(CHAL_W), .NUM_BYTES(NUM_BYTES),
      .ACK_CYCLES(ACK_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .chal_valid(chal_valid), .chal_data(chal_data), .chal_ready(chal_ready),
      .buf_ready(buf_ready), .buf_data(buf_data), .buf_ack_reset(buf_ack_reset),
      .race_en(race_en), .challenge(challenge),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .busy(busy), .byte_idx(byte_idx), .timeout_err(timeout_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0]        data;
      logic [CHAL_W-1:0] chal;
      logic [7:0]        idx;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         errors = 0;
   int         tx_mode = 1;   // 0: hold low, 1: always high, 2: random
   logic [7:0] req_bytes[NUM_BYTES];
   int         req_delays[NUM_BYTES];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Transmitter ready pattern, re-drawn each cycle.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         case (tx_mode)
            0:       tx_ready = 1'b0;
            1:       tx_ready = 1'b1;
            default: tx_ready = ($urandom_range(0, 2) != 0);
         endcase
      end
   end

   // Scoreboard monitor: every handshake must match the oldest expected byte.
   always @(negedge clock) begin : monitor
      exp_t e;
      if (reset_n && tx_valid && tx_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tx actual=%0h required=none (t=%0t)", tx_data, $time);
         end else begin
            e = exp_q.pop_front();
            check("tx_data", tx_data, e.data);
            check("tx_challenge", challenge, e.chal);
            check("tx_byte_idx", byte_idx, e.idx);
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_chal_ready"}, chal_ready, 1);
      check({tag, "_buf_ack_reset"}, buf_ack_reset, 0);
      check({tag, "_race_en"}, race_en, 0);
      check({tag, "_challenge"}, challenge, 0);
      check({tag, "_tx_valid"}, tx_valid, 0);
      check({tag, "_tx_data"}, tx_data, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_byte_idx"}, byte_idx, 0);
      check({tag, "_timeout_err"}, timeout_err, 0);
   endtask

   // Plays the smart buffer for one race: noise while not racing, then presents the
   // byte d cycles into RACE (d=0 means the first RACE cycle).
   task automatic race_byte(input int d, input logic [7:0] b);
      int guard = 0;
      int cnt = 0;
      while (!race_en && guard < 400) begin
         buf_ready  = 1'($urandom_range(0, 1));
         buf_data   = 8'h77;
         chal_valid = 1'($urandom_range(0, 1));
         chal_data  = CHAL_W'($urandom);
         tick;
         guard++;
      end
      chal_valid = 1'b0;
      if (!race_en) begin
         buf_ready = 1'b0;
         check("race_start_bound", race_en, 1);
         return;
      end
      while (race_en && cnt < 400) begin
         if (cnt == d) begin
            buf_ready = 1'b1;
            buf_data  = b;
         end else begin
            buf_ready = 1'b0;
            buf_data  = 8'($urandom);
         end
         tick;
         cnt++;
      end
      buf_ready = 1'b0;
      if (race_en) check("race_end_bound", race_en, 0);
   endtask

   task automatic request(input logic [CHAL_W-1:0] c, input bit measure, input bit hold_first);
      int   guard = 0;
      bit   aborted = 1'b0;
      exp_t e;
      while (!chal_ready && guard < 2000) begin
         tick;
         guard++;
      end
      check("idle_before_req", chal_ready, 1);
      chal_valid = 1'b1;
      chal_data  = c;
      tick;
      chal_valid = 1'b0;
      chal_data  = CHAL_W'($urandom);
      check("chal_ready_fall", chal_ready, 0);
      check("busy_rise", busy, 1);
      check("chal_latched", challenge, c);
      check("byte_idx_start", byte_idx, 0);
      check("timeout_err_cleared", timeout_err, 0);
      if (measure) begin
         int hi = 0;
         int rise = 0;
         for (int k = 1; k <= ACK_CYCLES + 1; k++) begin
            if (buf_ack_reset) hi++;
            if (race_en && rise == 0) rise = k;
            if (k <= ACK_CYCLES) tick;
         end
         check("ack_high_cycles", hi, ACK_CYCLES);
         check("race_en_rise_cycle", rise, ACK_CYCLES + 1);
         check("ack_low_in_race", buf_ack_reset, 0);
         check("challenge_at_race", challenge, c);
      end
      for (int i = 0; i < NUM_BYTES; i++) begin
         e.chal = c + CHAL_W'(i);
         e.idx  = 8'(i);
         if (TIMEOUT_ON && req_delays[i] >= TIMEOUT_CYCLES) begin
            e.data  = 8'hEE;
            aborted = 1'b1;
         end else begin
            e.data = req_bytes[i];
         end
         exp_q.push_back(e);
         race_byte(req_delays[i], req_bytes[i]);
         if (hold_first && i == 0) begin
            for (int k = 0; k < 10; k++) begin
               check("hold_tx_valid", tx_valid, 1);
               check("hold_tx_data", tx_data, e.data);
               check("hold_no_clear", {buf_ack_reset, race_en}, 2'b00);
               tick;
            end
            tx_mode = 2;
         end
         if (aborted) break;
      end
      guard = 0;
      while (busy && guard < 2000) begin
         tick;
         guard++;
      end
      check("idle_after_req", busy, 0);
      check("chal_ready_after_req", chal_ready, 1);
      check("timeout_err_after_req", timeout_err, aborted);
      check("scoreboard_drained", exp_q.size(), 0);
   endtask

   task automatic fill_random(input int maxd);
      for (int i = 0; i < NUM_BYTES; i++) begin
         req_bytes[i]  = 8'($urandom);
         req_delays[i] = $urandom_range(0, maxd);
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin : main
      exp_t e;
      int   guard;
      bit   seen;
      tick;
      tick;
      check_reset_vals("reset");
      reset_n = 1'b1;
      tick;

      // Directed: known bytes, zero-wait transmitter, latency measurement.
      tx_mode = 1;
      req_bytes  = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};
      req_delays = '{0, 2, 5, 1};
      request(16'h1234, 1'b1, 1'b0);

      // Transmitter stalls 10 cycles on the first byte.
      tx_mode = 0;
      fill_random(6);
      request(16'h00AB, 1'b0, 1'b1);

      // Challenge wrap.
      tx_mode = 2;
      fill_random(6);
      request(16'hFFFF, 1'b1, 1'b0);

      // Randomized requests.
      for (int r = 0; r < 8; r++) begin
         tx_mode = $urandom_range(1, 2);
         fill_random(12);
         request(CHAL_W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      end

`ifdef PUF_RACE_TIMEOUT_EN
      // Timeout with no buffer response, then response on the last allowed cycle.
      tx_mode = 2;
      fill_random(4);
      req_delays[0] = TIMEOUT_CYCLES + 4;
      request(16'h0BAD, 1'b0, 1'b0);
      fill_random(4);
      req_delays[0] = TIMEOUT_CYCLES - 1;
      request(16'h600D, 1'b0, 1'b0);
`endif

      // Asynchronous reset during the race of the second byte.
      tx_mode = 2;
      fill_random(3);
      chal_valid = 1'b1;
      chal_data  = 16'h4321;
      tick;
      chal_valid = 1'b0;
      e.data = req_bytes[0];
      e.chal = 16'h4321;
      e.idx  = 8'd0;
      exp_q.push_back(e);
      race_byte(1, req_bytes[0]);
      buf_ready = 1'b0;
      guard = 0;
      while (!race_en && guard < 400) begin
         tick;
         guard++;
      end
      check("second_race_reached", race_en, 1);
      check("second_race_idx", byte_idx, 1);
      #2 reset_n = 1'b0;
      #1 check_reset_vals("midreset");
      check("scoreboard_empty_at_reset", exp_q.size(), 0);
      exp_q.delete();
      repeat (3) tick;
      #2 reset_n = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         tick;
         if (tx_valid || busy) seen = 1'b1;
      end
      check("quiet_after_reset", seen, 0);

      // Normal operation resumes after reset.
      fill_random(8);
      request(CHAL_W'($urandom), 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
